hc_buffer_fifo: RTL and testbench
=================================

Name: hc_buffer_fifo

Overview:
- One cache-line buffer slot of the HardCloud buffer bank; one instance per buffer id, HC_BUFFER_SIZE instances total.
- Sits directly behind the buffers interface:
  - consumes the per-id control command (IDLE/ENQUEUE/DEQUEUE) and the per-id cl_data;
  - produces the per-id status (count/empty/full).
- A memory-side port lets the read/write stream engines fill and drain the same ring, and do offset-indexed access for indexed requests.

Parameters:
- DEPTH, 16, number of 512-bit entries; power of two, minimum 2.
- DATA_W, 512, entry width (CCI-P cache line).
- CNT_W, $clog2(DEPTH+1), width of the count.

Ports:
- clk  in  1  single clock.
- reset_n  in  1  asynchronous, active-low reset.
- ctrl_cmd  in  2  user command: IDLE/ENQUEUE/DEQUEUE (t_buffer_cmd).
- ctrl_data  in  DATA_W  user enqueue data (the per-id cl_data).
- head_data  out  DATA_W  entry at read pointer; combinational from storage.
- mem_push  in  1  stream engine pushes a fetched line.
- mem_push_data  in  DATA_W  pushed line.
- mem_pop  in  1  stream engine drains the head line.
- idx_we  in  1  indexed write strobe.
- idx_re  in  1  indexed read strobe.
- idx_offset  in  $clog2(DEPTH)  offset from the read pointer.
- idx_wdata  in  DATA_W  indexed write data.
- idx_rdata  out  DATA_W  indexed read data, registered.
- idx_rvalid  out  1  idx_rdata valid.
- status_count  out  CNT_W  current occupancy.
- status_empty  out  1  count==0.
- status_full  out  1  count==DEPTH.
- err_overflow  out  1  sticky: a push was dropped.
- err_underflow  out  1  sticky: a pop was dropped.
- err_index  out  1  sticky: an indexed access was out of range.

Behaviour:
- Reset (reset_n low, asynchronous):
  - pointers, count, idx_rvalid and all err_* go to 0;
  - status_empty=1, status_full=0;
  - idx_rdata=0;
  - storage contents are not reset; head_data is don't-care while empty.
  - Reset asserted mid-operation discards everything in flight. The first command is accepted on the first rising edge with reset_n high.
- Push source:
  - push = mem_push OR (ctrl_cmd==ENQUEUE).
  - If both are asserted in one cycle, mem_push wins. The user enqueue is dropped and err_overflow is set.
- Pop source:
  - pop = mem_pop OR (ctrl_cmd==DEQUEUE).
  - If both are asserted in one cycle, a single entry is popped and err_underflow is set.
- Push accepted:
  - if count<DEPTH, or if count==DEPTH and a pop is accepted in the same cycle;
  - otherwise dropped, err_overflow set.
- Pop accepted: only if count>0, otherwise dropped with err_underflow set. A push into an empty ring does not satisfy a same-cycle pop.
- On accepted push: mem[wr_ptr] <= data; wr_ptr <= wr_ptr+1 mod DEPTH (natural wrap, DEPTH power of two).
- On accepted pop: rd_ptr <= rd_ptr+1 mod DEPTH.
- count update: count <= count + push_acc - pop_acc. Status outputs derive from the registered count and are visible the cycle after the command.
- head_data = mem[rd_ptr].
  - Valid whenever status_empty==0.
  - After a push into an empty ring, it is valid in the next cycle.
- Indexed access:
  - effective address = rd_ptr+idx_offset mod DEPTH;
  - legal only if idx_offset < count (count sampled before this cycle's push/pop).
- idx_we (legal): overwrites that entry; pointers and count unchanged.
  - If it targets the entry being popped in the same cycle, the write still lands and the pop still occurs.
  - If idx_we and an accepted push target the same address, the push data wins.
- idx_re (legal): idx_rdata is registered storage data, with idx_rvalid=1 exactly one cycle later (latency 1). It reads pre-write data when a write to that address occurs in the same cycle.
- Illegal indexed access:
  - write suppressed;
  - idx_rvalid stays 0;
  - err_index set.
- err_* bits are cleared only by reset.

Decomposition:
- hc_pkg gains:
  - t_buffer_cmd enum {e_BUFFER_IDLE=0, e_BUFFER_ENQUEUE=1, e_BUFFER_DEQUEUE=2};
  - t_buffer_data (512 bits);
  - t_buffer_size (CNT_W);
  - the t_buffer_status struct {count, empty, full};
  - HC_BUFFER_DEPTH constant.
- Sub-module hc_buffer_ram: DEPTH x DATA_W storage with one write port, one combinational read port (head) and one registered read port (indexed).
- Pointer/count/error logic stays in hc_buffer_fifo.

Test Plan:
- Reset then 4 ENQUEUEs of 0x1..0x4 -> count=4, empty=0, head_data=0x1; 4 DEQUEUEs -> head sequence 0x1,0x2,0x3,0x4, then count=0, empty=1.
- Fill DEPTH=16 via mem_push, 17th push -> full=1, count=16, err_overflow=1; same-cycle push+pop at full -> count stays 16, head advances.
- DEQUEUE on empty -> count stays 0, err_underflow=1; simultaneous mem_push and ENQUEUE -> count+1 and only the mem_push_data is stored.
- Wrap: push 20 lines, popping so occupancy ≤16 -> FIFO order preserved across pointer wrap.
- Indexed: count=5, idx_offset=3 with idx_wdata=0xAB -> pop 3 entries, head_data=0xAB; idx_re at offset 5 -> no idx_rvalid, err_index=1; idx_re at offset 0 -> idx_rvalid one cycle later with head value.
- Assert reset_n low with count=7 -> immediately count=0, empty=1, all err_*=0.

Source files
------------

// File: rtl/hc_pkg.sv
// Shared HardCloud types and constants for the buffer bank.
// Contains the per-buffer command, data, size and status types.
package hc_pkg;

    localparam int HC_BUFFER_DEPTH = 16;
    localparam int HC_DATA_W       = 512;
    localparam int HC_BUFFER_CNT_W = $clog2(HC_BUFFER_DEPTH + 1);

    typedef enum logic [1:0] {
        e_BUFFER_IDLE    = 2'd0,
        e_BUFFER_ENQUEUE = 2'd1,
        e_BUFFER_DEQUEUE = 2'd2
    } t_buffer_cmd;

    typedef logic [HC_DATA_W-1:0]       t_buffer_data;
    typedef logic [HC_BUFFER_CNT_W-1:0] t_buffer_size;

    typedef struct packed {
        t_buffer_size count;
        logic         empty;
        logic         full;
    } t_buffer_status;

endpackage

// File: rtl/hc_buffer_ram.sv
// Ring storage for one buffer slot: push and indexed write ports,
// combinational head read and a registered indexed read.
module hc_buffer_ram #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 512,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_push_we,
    input  logic [AW-1:0]     i_push_addr,
    input  logic [DATA_W-1:0] i_push_data,
    input  logic              i_idx_we,
    input  logic              i_idx_re,
    input  logic [AW-1:0]     i_idx_addr,
    input  logic [DATA_W-1:0] i_idx_wdata,
    input  logic [AW-1:0]     i_head_addr,
    output logic [DATA_W-1:0] o_head_data,
    output logic [DATA_W-1:0] o_idx_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_idx_rdata;

    // Push data takes precedence when both ports hit the same entry.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (i_push_we && (i_push_addr == AW'(gi))) begin
                    r_mem[gi] <= i_push_data;
                end else if (i_idx_we && (i_idx_addr == AW'(gi))) begin
                    r_mem[gi] <= i_idx_wdata;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_idx_rdata <= '0;
        end else if (i_idx_re) begin
            r_idx_rdata <= r_mem[i_idx_addr];
        end
    end

    assign o_head_data = r_mem[i_head_addr];
    assign o_idx_rdata = r_idx_rdata;

endmodule

// File: rtl/hc_buffer_fifo.sv
// One HardCloud buffer slot: a ring FIFO shared by the user command port
// and the memory stream engines, with offset-indexed access from the head.
module hc_buffer_fifo
    import hc_pkg::*;
#(
    parameter int DEPTH  = HC_BUFFER_DEPTH,
    parameter int DATA_W = HC_DATA_W,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  t_buffer_cmd              ctrl_cmd,
    input  logic [DATA_W-1:0]        ctrl_data,
    output logic [DATA_W-1:0]        head_data,
    input  logic                     mem_push,
    input  logic [DATA_W-1:0]        mem_push_data,
    input  logic                     mem_pop,
    input  logic                     idx_we,
    input  logic                     idx_re,
    input  logic [$clog2(DEPTH)-1:0] idx_offset,
    input  logic [DATA_W-1:0]        idx_wdata,
    output logic [DATA_W-1:0]        idx_rdata,
    output logic                     idx_rvalid,
    output logic [CNT_W-1:0]         status_count,
    output logic                     status_empty,
    output logic                     status_full,
    output logic                     err_overflow,
    output logic                     err_underflow,
    output logic                     err_index
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_idx_rvalid;
    logic             r_err_overflow;
    logic             r_err_underflow;
    logic             r_err_index;

    logic              w_user_push;
    logic              w_user_pop;
    logic              w_push_req;
    logic              w_pop_req;
    logic              w_push_acc;
    logic              w_pop_acc;
    logic              w_full;
    logic              w_empty;
    logic [DATA_W-1:0] w_push_data;
    logic              w_idx_legal;
    logic [AW-1:0]     w_idx_addr;
    logic              w_ovf_event;
    logic              w_unf_event;
    logic              w_idx_event;

    assign w_user_push = (ctrl_cmd == e_BUFFER_ENQUEUE);
    assign w_user_pop  = (ctrl_cmd == e_BUFFER_DEQUEUE);
    assign w_push_req  = mem_push | w_user_push;
    assign w_pop_req   = mem_pop | w_user_pop;
    assign w_push_data = mem_push ? mem_push_data : ctrl_data;

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);

    // A pop frees a slot in the same cycle, but a push never feeds a same-cycle pop.
    assign w_pop_acc  = w_pop_req && !w_empty;
    assign w_push_acc = w_push_req && (!w_full || w_pop_acc);

    assign w_idx_legal = (CNT_W'(idx_offset) < r_count);
    assign w_idx_addr  = r_rd_ptr + idx_offset;

    assign w_ovf_event = (mem_push && w_user_push) || (w_push_req && !w_push_acc);
    assign w_unf_event = (mem_pop && w_user_pop) || (w_pop_req && !w_pop_acc);
    assign w_idx_event = (idx_we || idx_re) && !w_idx_legal;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_ptr        <= '0;
            r_wr_ptr        <= '0;
            r_count         <= '0;
            r_idx_rvalid    <= 1'b0;
            r_err_overflow  <= 1'b0;
            r_err_underflow <= 1'b0;
            r_err_index     <= 1'b0;
        end else begin
            if (w_push_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_acc) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count         <= r_count + CNT_W'(w_push_acc) - CNT_W'(w_pop_acc);
            r_idx_rvalid    <= idx_re && w_idx_legal;
            r_err_overflow  <= r_err_overflow | w_ovf_event;
            r_err_underflow <= r_err_underflow | w_unf_event;
            r_err_index     <= r_err_index | w_idx_event;
        end
    end

    hc_buffer_ram #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .AW     (AW)
    ) u_ram (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_push_we   (w_push_acc),
        .i_push_addr (r_wr_ptr),
        .i_push_data (w_push_data),
        .i_idx_we    (idx_we && w_idx_legal),
        .i_idx_re    (idx_re && w_idx_legal),
        .i_idx_addr  (w_idx_addr),
        .i_idx_wdata (idx_wdata),
        .i_head_addr (r_rd_ptr),
        .o_head_data (head_data),
        .o_idx_rdata (idx_rdata)
    );

    assign idx_rvalid    = r_idx_rvalid;
    assign status_count  = r_count;
    assign status_empty  = w_empty;
    assign status_full   = w_full;
    assign err_overflow  = r_err_overflow;
    assign err_underflow = r_err_underflow;
    assign err_index     = r_err_index;

endmodule

// File: tb/tb_hc_buffer_fifo.sv
// Directed self-checking bench for hc_buffer_fifo (DEPTH=16, DATA_W=512).
module tb_hc_buffer_fifo;
    import hc_pkg::*;

    localparam int DEPTH  = 16;
    localparam int DATA_W = 512;
    localparam int CNT_W  = 5;
    localparam int AW     = 4;

    logic              clk;
    logic              reset_n;
    t_buffer_cmd       ctrl_cmd;
    logic [DATA_W-1:0] ctrl_data;
    logic [DATA_W-1:0] head_data;
    logic              mem_push;
    logic [DATA_W-1:0] mem_push_data;
    logic              mem_pop;
    logic              idx_we;
    logic              idx_re;
    logic [AW-1:0]     idx_offset;
    logic [DATA_W-1:0] idx_wdata;
    logic [DATA_W-1:0] idx_rdata;
    logic              idx_rvalid;
    logic [CNT_W-1:0]  status_count;
    logic              status_empty;
    logic              status_full;
    logic              err_overflow;
    logic              err_underflow;
    logic              err_index;

    int total = 0;
    int bad   = 0;

    hc_buffer_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .ctrl_cmd      (ctrl_cmd),
        .ctrl_data     (ctrl_data),
        .head_data     (head_data),
        .mem_push      (mem_push),
        .mem_push_data (mem_push_data),
        .mem_pop       (mem_pop),
        .idx_we        (idx_we),
        .idx_re        (idx_re),
        .idx_offset    (idx_offset),
        .idx_wdata     (idx_wdata),
        .idx_rdata     (idx_rdata),
        .idx_rvalid    (idx_rvalid),
        .status_count  (status_count),
        .status_empty  (status_empty),
        .status_full   (status_full),
        .err_overflow  (err_overflow),
        .err_underflow (err_underflow),
        .err_index     (err_index)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-16s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic idle_inputs();
        ctrl_cmd      = e_BUFFER_IDLE;
        ctrl_data     = '0;
        mem_push      = 1'b0;
        mem_push_data = '0;
        mem_pop       = 1'b0;
        idx_we        = 1'b0;
        idx_re        = 1'b0;
        idx_offset    = '0;
        idx_wdata     = '0;
    endtask

    // Apply current inputs for one rising edge, then return inputs to idle.
    task automatic step();
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        int exp_seq;
        reset_n = 1'b1;
        idle_inputs();
        #2;
        do_reset();

        // Reset state
        chk("rst_count", DATA_W'(status_count), 0);
        chk("rst_empty", DATA_W'(status_empty), 1);
        chk("rst_full", DATA_W'(status_full), 0);
        chk("rst_errs", DATA_W'({err_overflow, err_underflow, err_index}), 0);
        chk("rst_rvalid", DATA_W'(idx_rvalid), 0);
        chk("rst_rdata", idx_rdata, 0);

        // Four user enqueues then four dequeues
        for (int i = 1; i <= 4; i++) begin
            ctrl_cmd = e_BUFFER_ENQUEUE; ctrl_data = DATA_W'(i);
            step();
        end
        chk("enq_count", DATA_W'(status_count), 4);
        chk("enq_empty", DATA_W'(status_empty), 0);
        chk("enq_head", head_data, 1);
        for (int i = 1; i <= 4; i++) begin
            chk("deq_head", head_data, DATA_W'(i));
            ctrl_cmd = e_BUFFER_DEQUEUE;
            step();
        end
        chk("deq_count", DATA_W'(status_count), 0);
        chk("deq_empty", DATA_W'(status_empty), 1);

        // Fill via mem_push, overflow, push+pop at full
        for (int i = 0; i < DEPTH; i++) begin
            mem_push = 1'b1; mem_push_data = DATA_W'(32'h100 + i);
            step();
        end
        chk("fill_full", DATA_W'(status_full), 1);
        chk("fill_ovf0", DATA_W'(err_overflow), 0);
        mem_push = 1'b1; mem_push_data = DATA_W'(32'hDEAD);
        step();
        chk("ovf_count", DATA_W'(status_count), 16);
        chk("ovf_flag", DATA_W'(err_overflow), 1);
        chk("ovf_head", head_data, 32'h100);
        mem_push = 1'b1; mem_push_data = DATA_W'(32'h200); mem_pop = 1'b1;
        step();
        chk("pp_count", DATA_W'(status_count), 16);
        chk("pp_head", head_data, 32'h101);
        for (int i = 0; i < DEPTH; i++) begin
            chk("drain_head", head_data, (i == 15) ? DATA_W'(32'h200) : DATA_W'(32'h101 + i));
            mem_pop = 1'b1;
            step();
        end
        chk("drain_empty", DATA_W'(status_empty), 1);
        chk("drain_unf0", DATA_W'(err_underflow), 0);

        // Underflow and push-source collision
        do_reset();
        ctrl_cmd = e_BUFFER_DEQUEUE;
        step();
        chk("unf_count", DATA_W'(status_count), 0);
        chk("unf_flag", DATA_W'(err_underflow), 1);
        mem_push = 1'b1; mem_push_data = DATA_W'(32'hAA);
        ctrl_cmd = e_BUFFER_ENQUEUE; ctrl_data = DATA_W'(32'hBB);
        step();
        chk("coll_count", DATA_W'(status_count), 1);
        chk("coll_head", head_data, 32'hAA);
        chk("coll_ovf", DATA_W'(err_overflow), 1);
        mem_pop = 1'b1; ctrl_cmd = e_BUFFER_DEQUEUE;
        step();
        chk("dpop_count", DATA_W'(status_count), 0);

        // Wrap: 20 pushes with occupancy kept at or below 10
        do_reset();
        exp_seq = 0;
        for (int i = 0; i < 10; i++) begin
            mem_push = 1'b1; mem_push_data = DATA_W'(32'h300 + i);
            step();
        end
        for (int i = 10; i < 20; i++) begin
            chk("wrap_head", head_data, DATA_W'(32'h300 + exp_seq));
            exp_seq++;
            mem_push = 1'b1; mem_push_data = DATA_W'(32'h300 + i); mem_pop = 1'b1;
            step();
        end
        chk("wrap_count", DATA_W'(status_count), 10);
        for (int i = 0; i < 10; i++) begin
            chk("wrap_tail", head_data, DATA_W'(32'h300 + exp_seq));
            exp_seq++;
            mem_pop = 1'b1;
            step();
        end
        chk("wrap_empty", DATA_W'(status_empty), 1);

        // Indexed access
        do_reset();
        for (int i = 0; i < 5; i++) begin
            ctrl_cmd = e_BUFFER_ENQUEUE; ctrl_data = DATA_W'(32'h10 + i);
            step();
        end
        idx_we = 1'b1; idx_offset = 4'd3; idx_wdata = DATA_W'(32'hAB);
        step();
        chk("iw_count", DATA_W'(status_count), 5);
        chk("iw_head", head_data, 32'h10);
        for (int i = 0; i < 3; i++) begin
            ctrl_cmd = e_BUFFER_DEQUEUE;
            step();
        end
        chk("iw_popped", head_data, 32'hAB);
        idx_re = 1'b1; idx_offset = 4'd5;
        step();
        chk("ibad_rvalid", DATA_W'(idx_rvalid), 0);
        chk("ibad_err", DATA_W'(err_index), 1);
        idx_re = 1'b1; idx_offset = 4'd0;
        step();
        chk("ir_rvalid", DATA_W'(idx_rvalid), 1);
        chk("ir_rdata", idx_rdata, 32'hAB);
        step();
        chk("ir_rvalid_off", DATA_W'(idx_rvalid), 0);
        idx_re = 1'b1; idx_we = 1'b1; idx_offset = 4'd1; idx_wdata = DATA_W'(32'hCD);
        step();
        chk("rw_old", idx_rdata, 32'h14);
        idx_re = 1'b1; idx_offset = 4'd1;
        step();
        chk("rw_new", idx_rdata, 32'hCD);

        // Asynchronous reset mid-operation with count=7
        for (int i = 0; i < 5; i++) begin
            mem_push = 1'b1; mem_push_data = DATA_W'(32'h500 + i);
            step();
        end
        chk("pre_count", DATA_W'(status_count), 7);
        reset_n = 1'b0;
        #1;
        chk("arst_count", DATA_W'(status_count), 0);
        chk("arst_empty", DATA_W'(status_empty), 1);
        chk("arst_errs", DATA_W'({err_overflow, err_underflow, err_index}), 0);
        chk("arst_rvalid", DATA_W'(idx_rvalid), 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        ctrl_cmd = e_BUFFER_ENQUEUE; ctrl_data = DATA_W'(32'h77);
        step();
        chk("post_count", DATA_W'(status_count), 1);
        chk("post_head", head_data, 32'h77);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
